sipo_frame_ctrl: RTL and testbench
==================================

// Module: sipo_frame_ctrl
// PURPOSE
//   Sequencer for the 8-bit serial-in/parallel-out shift register used on the board.
//   Watches a serial line, detects start bit, times mid-bit sample points and
//   issues one-cycle shift strobes so the SIPO captures exactly DATA_BITS bits.
//   Checks the stop bit, latches the parallel word and offers it to the consumer
//   with a valid/ready handshake; flags framing errors and overruns.
// PARAMETERS
//   DATA_BITS     8   bits per frame; width of sr_data / frame_data
//   CLKS_PER_BIT  16  clk cycles per serial bit (must be even, >= 4)
//   CNT_W         8   width of bit-timer counter; must hold CLKS_PER_BIT-1
// PORTS
//   clk          in   1          system clock, all logic on posedge
//   reset        in   1          asynchronous, active-low reset
//   rx_in        in   1          asynchronous serial line, idle high
//   sr_clear     out  1          one-cycle clear strobe to SIPO (SIPO sync reset)
//   sr_shift     out  1          one-cycle shift-enable to SIPO
//   sr_bit       out  1          synchronized serial bit presented to SIPO input
//   sr_data      in   DATA_BITS  parallel contents of SIPO
//   frame_data   out  DATA_BITS  last accepted word
//   frame_valid  out  1          frame_data holds an unconsumed word
//   frame_ready  in   1          consumer accepts word when valid & ready
//   frame_err    out  1          one-cycle pulse: stop bit sampled low
//   overrun      out  1          one-cycle pulse: good frame dropped, valid still high
//   busy         out  1          high in any state other than IDLE
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, timer=0, bitcnt=0, sync flops=1;
//     sr_clear=0, sr_shift=0, frame_data=0, frame_valid=0, frame_err=0,
//     overrun=0, busy=0. Reset mid-frame aborts frame; no valid/err pulse.
//   rx_in passes a 2-flop synchronizer (rx_s, reset value 1); sr_bit = rx_s.
//   All outputs registered.
//   FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: on rx_s==0 go START, timer=0, assert sr_clear for that one cycle.
//   START: count to CLKS_PER_BIT/2-1; then sample rx_s: 0 -> DATA, timer=0,
//     bitcnt=0; 1 -> false start, back to IDLE, no flags.
//   DATA: timer counts 0..CLKS_PER_BIT-1 and wraps; at wrap assert sr_shift
//     one cycle (mid-bit), bitcnt++. After DATA_BITS-th shift go STOP, timer=0.
//     First received bit ends at sr_data[DATA_BITS-1] (SIPO shifts toward MSB).
//   STOP: at timer wrap sample rx_s:
//     1 and frame_valid==0 (or being consumed same cycle) -> frame_data<=sr_data,
//       frame_valid<=1 next cycle;
//     1 and frame_valid==1 and !frame_ready -> overrun pulse, word dropped;
//     0 -> frame_err pulse, frame_data/frame_valid unchanged. Always -> IDLE.
//   Handshake: frame_valid stays high, frame_data stable, until valid&ready;
//     valid falls next cycle. Simultaneous accept + new latch -> valid stays 1,
//     frame_data takes new word, no overrun.
//   rx_in low in IDLE right after STOP -> new START immediately (back-to-back).
//   rx_in changes during START/DATA/STOP other than at sample points: ignored.
//   Latency: frame_valid rises 1 cycle after stop-bit sample point.
// TESTING (bench uses CLKS_PER_BIT=4, DATA_BITS=8)
//   Reset: hold reset=0 with rx_in toggling -> all outputs 0, busy=0.
//   Frame 0xA5 (bits 1,0,1,0,0,1,0,1 first-to-last), stop=1 -> exactly 8
//     sr_shift pulses, frame_valid=1, frame_data=8'hA5; ready=1 -> valid drops.
//   Glitch: rx_in low 1 cycle in IDLE -> START, false start, IDLE, no shift.
//   Stop bit=0 on frame 0x3C -> frame_err 1-cycle pulse, frame_valid stays 0.
//   Two frames 0x11,0x22 back-to-back, ready=0 -> valid with 0x11, overrun
//     pulse at second stop, frame_data remains 0x11.
//   reset=0 after 4th sr_shift -> IDLE immediately; next frame 0x7E received ok.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial frame sequencer for an external SIPO: detects the start bit, strobes mid-bit
// shifts, checks the stop bit and hands the captured word over with valid/ready.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronized input
// START | timing to the middle of the start bit to reject glitches
// DATA  | one shift strobe per bit period, DATA_BITS in total
// STOP  | sampling the stop bit, then latch / overrun / framing error
module sipo_frame_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic                 sr_clear,
  output logic                 sr_shift,
  output logic                 sr_bit,
  input  logic [DATA_BITS-1:0] sr_data,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     timer, timer_nxt;
  logic [BIT_W-1:0]     bitcnt, bitcnt_nxt;
  logic                 rx_m, rx_s;
  logic                 clear_nxt, shift_nxt, err_nxt, ovr_nxt, valid_nxt, busy_nxt;
  logic [DATA_BITS-1:0] data_nxt;

  assign sr_bit = rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      timer       <= '0;
      bitcnt      <= '0;
      sr_clear    <= 1'b0;
      sr_shift    <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_m        <= rx_in;
      rx_s        <= rx_m;
      state       <= state_nxt;
      timer       <= timer_nxt;
      bitcnt      <= bitcnt_nxt;
      sr_clear    <= clear_nxt;
      sr_shift    <= shift_nxt;
      frame_data  <= data_nxt;
      frame_valid <= valid_nxt;
      frame_err   <= err_nxt;
      overrun     <= ovr_nxt;
      busy        <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    bitcnt_nxt = bitcnt;
    clear_nxt  = 1'b0;
    shift_nxt  = 1'b0;
    err_nxt    = 1'b0;
    ovr_nxt    = 1'b0;
    data_nxt   = frame_data;
    valid_nxt  = frame_valid & ~frame_ready;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          timer_nxt = '0;
          clear_nxt = 1'b1;
        end
      end
      START: begin
        if (timer == HALF_TC) begin
          timer_nxt  = '0;
          bitcnt_nxt = '0;
          state_nxt  = rx_s ? IDLE : DATA;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DATA: begin
        if (timer == FULL_TC) begin
          timer_nxt  = '0;
          shift_nxt  = 1'b1;
          bitcnt_nxt = bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) state_nxt = STOP;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      STOP: begin
        if (timer == FULL_TC) begin
          timer_nxt = '0;
          state_nxt = IDLE;
          // A word being accepted this cycle frees the holding register for the new one.
          if (!rx_s) begin
            err_nxt = 1'b1;
          end else if (!frame_valid || frame_ready) begin
            data_nxt  = sr_data;
            valid_nxt = 1'b1;
          end else begin
            ovr_nxt = 1'b1;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl with a behavioural SIPO and a scoreboard of
// words expected on the frame output.
module tb_sipo_frame_ctrl;

  localparam int DB  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_in = 1'b1;
  logic          frame_ready = 1'b0;
  logic          sr_clear, sr_shift, sr_bit, frame_valid, frame_err, overrun, busy;
  logic [DB-1:0] sr_data, frame_data;
  logic [DB-1:0] sipo = '0;

  int tests = 0;
  int fails = 0;
  int shift_cnt = 0, clr_cnt = 0, err_cnt = 0, ovr_cnt = 0;
  logic [DB-1:0] exp_q[$];

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .rx_in(rx_in),
    .sr_clear(sr_clear), .sr_shift(sr_shift), .sr_bit(sr_bit), .sr_data(sr_data),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  // external shift register: shifts toward the MSB
  always @(posedge clk) begin
    if (sr_clear) sipo <= '0;
    else if (sr_shift) sipo <= {sipo[DB-2:0], sr_bit};
  end
  assign sr_data = sipo;

  always @(negedge clk) begin
    if (sr_shift) shift_cnt++;
    if (sr_clear) clr_cnt++;
    if (frame_err) err_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = DB - 1; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!frame_valid && n < 40) begin
      tick(1);
      n++;
    end
    check(tag, 32'(frame_valid), 32'd1);
  endtask

  task automatic check_pop(input string tag);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd0, 32'd1);
    else check(tag, 32'(frame_data), 32'(exp_q.pop_front()));
  endtask

  initial begin
    int s0, c0, e0, o0;

    // reset held low while the line toggles
    for (int i = 0; i < 6; i++) begin
      rx_in = i[0];
      tick(1);
    end
    check("rst_sr_clear", 32'(sr_clear), 32'd0);
    check("rst_sr_shift", 32'(sr_shift), 32'd0);
    check("rst_sr_bit", 32'(sr_bit), 32'd1);
    check("rst_frame_data", 32'(frame_data), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rx_in = 1'b1;
    reset = 1'b1;
    tick(4);

    // frame 0xA5, good stop bit
    s0 = shift_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_valid("a5_valid");
    check("a5_shifts", 32'(shift_cnt - s0), 32'd8);
    check("a5_sipo", 32'(sr_data), 32'hA5);
    check_pop("a5_data");
    check("a5_busy_idle", 32'(busy), 32'd0);
    tick(3);
    check("a5_valid_held", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("a5_valid_drop", 32'(frame_valid), 32'd0);

    // one-cycle glitch: false start
    s0 = shift_cnt;
    c0 = clr_cnt;
    rx_in = 1'b0;
    tick(1);
    rx_in = 1'b1;
    tick(2);
    check("glitch_start_busy", 32'(busy), 32'd1);
    tick(10);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_shift", 32'(shift_cnt - s0), 32'd0);
    check("glitch_clear", 32'(clr_cnt - c0), 32'd1);
    check("glitch_no_valid", 32'(frame_valid), 32'd0);

    // stop bit low on 0x3C
    s0 = shift_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0);
    rx_in = 1'b1;
    tick(12);
    check("err_pulse_cycles", 32'(err_cnt - e0), 32'd1);
    check("err_shifts", 32'(shift_cnt - s0), 32'd8);
    check("err_no_valid", 32'(frame_valid), 32'd0);
    check("err_busy_idle", 32'(busy), 32'd0);

    // back-to-back 0x11, 0x22 with consumer stalled
    o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rx_in = 1'b1;
    tick(4);
    check("b2b_overrun", 32'(ovr_cnt - o0), 32'd1);
    check("b2b_valid", 32'(frame_valid), 32'd1);
    check_pop("b2b_data");
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("b2b_valid_drop", 32'(frame_valid), 32'd0);

    // reset after the 4th shift of a frame
    s0 = shift_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("mid_shifts", 32'(shift_cnt - s0), 32'd4);
    reset = 1'b0;
    rx_in = 1'b1;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_shift_low", 32'(sr_shift), 32'd0);
    check("mid_data_clr", 32'(frame_data), 32'd0);
    tick(3);
    reset = 1'b1;
    tick(4);
    check("mid_still_idle", 32'(busy), 32'd0);

    s0 = shift_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_valid("7e_valid");
    check("7e_shifts", 32'(shift_cnt - s0), 32'd8);
    check_pop("7e_data");
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
